// File: rtl/boot_pkg.sv
// Shared definitions for the flash boot loader.
//   boot_state_e   : controller states (IDLE=0, CMD=1, LOAD=2, DONE=3, ERR=4)
//   *_DEF          : default image location, length and idle timeout
package boot_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CMD  = 3'd1,
    LOAD = 3'd2,
    DONE = 3'd3,
    ERR  = 3'd4
  } boot_state_e;

  localparam logic [23:0] BOOT_BASE_DEF  = 24'h010000;
  localparam int unsigned BOOT_BYTES_DEF = 65536;
  localparam int unsigned TIMEOUT_DEF    = 65535;

endpackage

// File: rtl/flash_boot_ctrl_if.sv
// Flash reader command/data path plus the byte-laned IMEM write port.
//   master : boot controller side (drives command and RAM write)
//   slave  : flash reader / IMEM side
interface flash_boot_ctrl_if #(
  parameter int unsigned IMEM_WIDTH  = 19,
  parameter int unsigned FLASH_WIDTH = 24
);

  logic                   flash_cmd_valid;
  logic                   flash_cmd_ready;
  logic [FLASH_WIDTH-1:0] flash_cmd_addr;
  logic [IMEM_WIDTH:0]    flash_cmd_len;
  logic [7:0]             flash_rdata;
  logic                   flash_rdata_valid;
  logic [IMEM_WIDTH-3:0]  ram_addr;
  logic [3:0]             ram_wen;
  logic [7:0]             ram_din;

  modport master (
    output flash_cmd_valid, flash_cmd_addr, flash_cmd_len,
    input  flash_cmd_ready, flash_rdata, flash_rdata_valid,
    output ram_addr, ram_wen, ram_din
  );

  modport slave (
    input  flash_cmd_valid, flash_cmd_addr, flash_cmd_len,
    output flash_cmd_ready, flash_rdata, flash_rdata_valid,
    input  ram_addr, ram_wen, ram_din
  );

endinterface

// File: rtl/boot_lane_writer.sv
// Byte counter, lane decode, registered IMEM write and running checksum.
//   clk, rst     : clock, async active-high reset
//   clr_i        : restart the image (clears count and checksum)
//   en_i         : strobes are accepted only while enabled
//   strobe_i     : one byte per asserted cycle on data_i
//   ram_addr_o/ram_wen_o/ram_din_o : write registered one cycle after strobe
//   csum_o       : modulo-2^16 sum of accepted bytes
//   last_o       : current strobe is the final image byte
module boot_lane_writer
  import boot_pkg::*;
#(
  parameter int unsigned IMEM_WIDTH = 19,
  parameter int unsigned BOOT_BYTES = BOOT_BYTES_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr_i,
  input  logic                  en_i,
  input  logic                  strobe_i,
  input  logic [7:0]            data_i,
  output logic [IMEM_WIDTH-3:0] ram_addr_o,
  output logic [3:0]            ram_wen_o,
  output logic [7:0]            ram_din_o,
  output logic [15:0]           csum_o,
  output logic                  last_o
);

  localparam logic [IMEM_WIDTH:0] LAST_CNT = (IMEM_WIDTH+1)'(BOOT_BYTES - 1);

  logic [IMEM_WIDTH:0]   cnt_q, cnt_d;
  logic [15:0]           csum_q, csum_d;
  logic [IMEM_WIDTH-3:0] addr_q, addr_d;
  logic [3:0]            wen_q, wen_d;
  logic [7:0]            din_q, din_d;
  logic                  accept;

  assign accept = en_i & strobe_i;
  assign last_o = accept && (cnt_q == LAST_CNT);

  always_comb begin
    cnt_d  = cnt_q;
    csum_d = csum_q;
    addr_d = addr_q;
    din_d  = din_q;
    wen_d  = '0;
    if (clr_i) begin
      cnt_d  = '0;
      csum_d = '0;
    end else if (accept) begin
      cnt_d  = cnt_q + 1'b1;
      csum_d = csum_q + {8'h00, data_i};
      addr_d = cnt_q[IMEM_WIDTH-1:2];
      din_d  = data_i;
      wen_d  = 4'b0001 << cnt_q[1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      csum_q <= '0;
      addr_q <= '0;
      wen_q  <= '0;
      din_q  <= '0;
    end else begin
      cnt_q  <= cnt_d;
      csum_q <= csum_d;
      addr_q <= addr_d;
      wen_q  <= wen_d;
      din_q  <= din_d;
    end
  end

  assign ram_addr_o = addr_q;
  assign ram_wen_o  = wen_q;
  assign ram_din_o  = din_q;
  assign csum_o     = csum_q;

endmodule

// File: rtl/flash_boot_ctrl.sv
// Boot sequencer: issues one burst read to the flash reader, steers the
// returned bytes into the four IMEM byte lanes and holds the CPU in reset
// until the image is in place.
//   clk, rst      : clock, async active-high reset
//   boot_start    : one-cycle (re)load request, ignored while busy
//   bus           : flash command/data and IMEM write port (master side)
//   cpu_rst_hold  : CPU reset hold, released one cycle after DONE
//   boot_busy     : CMD or LOAD
//   boot_done / boot_err : sticky status until the next start
//   boot_csum     : modulo-2^16 sum of loaded bytes
module flash_boot_ctrl
  import boot_pkg::*;
#(
  parameter int unsigned          IMEM_WIDTH  = 19,
  parameter int unsigned          FLASH_WIDTH = 24,
  parameter logic [FLASH_WIDTH-1:0] BOOT_BASE = FLASH_WIDTH'(BOOT_BASE_DEF),
  parameter int unsigned          BOOT_BYTES  = BOOT_BYTES_DEF,
  parameter int unsigned          TIMEOUT     = TIMEOUT_DEF,
  parameter bit                   AUTO_BOOT   = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     boot_start,
  flash_boot_ctrl_if.master        bus,
  output logic                     cpu_rst_hold,
  output logic                     boot_busy,
  output logic                     boot_done,
  output logic                     boot_err,
  output logic [15:0]              boot_csum
);

  localparam int unsigned         TW       = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0]       TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [IMEM_WIDTH:0] LEN      = (IMEM_WIDTH+1)'(BOOT_BYTES);

  boot_state_e   state_q, state_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          hold_q, hold_d;
  logic          auto_q;
  logic          lane_clr;
  logic          lane_last;

  always_comb begin
    state_d  = state_q;
    tmo_d    = tmo_q;
    lane_clr = 1'b0;
    unique case (state_q)
      IDLE: if (boot_start || auto_q) state_d = CMD;
      CMD: begin
        if (bus.flash_cmd_ready) begin
          state_d = LOAD;
          tmo_d   = '0;
        end else begin
          tmo_d = tmo_q + 1'b1;
          if (tmo_q == TMO_LAST) state_d = ERR;
        end
      end
      LOAD: begin
        if (bus.flash_rdata_valid) begin
          tmo_d = '0;
          if (lane_last) state_d = DONE;
        end else begin
          tmo_d = tmo_q + 1'b1;
          if (tmo_q == TMO_LAST) state_d = ERR;
        end
      end
      DONE, ERR: if (boot_start) state_d = CMD;
      default: state_d = IDLE;
    endcase

    if (state_d == CMD && state_q != CMD) begin
      lane_clr = 1'b1;
      tmo_d    = '0;
    end

    // Released only once DONE has been occupied for a full cycle, so the
    // final RAM write (registered on the DONE-entry edge) lands first.
    hold_d = !(state_q == DONE && state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      tmo_q   <= '0;
      hold_q  <= 1'b1;
      auto_q  <= AUTO_BOOT;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      hold_q  <= hold_d;
      auto_q  <= 1'b0;
    end
  end

  boot_lane_writer #(
    .IMEM_WIDTH (IMEM_WIDTH),
    .BOOT_BYTES (BOOT_BYTES)
  ) u_lane (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (lane_clr),
    .en_i       (state_q == LOAD),
    .strobe_i   (bus.flash_rdata_valid),
    .data_i     (bus.flash_rdata),
    .ram_addr_o (bus.ram_addr),
    .ram_wen_o  (bus.ram_wen),
    .ram_din_o  (bus.ram_din),
    .csum_o     (boot_csum),
    .last_o     (lane_last)
  );

  assign bus.flash_cmd_valid = (state_q == CMD);
  assign bus.flash_cmd_addr  = BOOT_BASE;
  assign bus.flash_cmd_len   = LEN;
  assign boot_busy           = (state_q == CMD) || (state_q == LOAD);
  assign boot_done           = (state_q == DONE);
  assign boot_err            = (state_q == ERR);
  assign cpu_rst_hold        = hold_q;

endmodule

// File: tb/tb_flash_boot_ctrl.sv
module tb_flash_boot_ctrl;

  localparam int unsigned IW   = 19;
  localparam int unsigned FW   = 24;
  localparam int          NB   = 8;
  localparam int          TMO  = 16;
  localparam logic [23:0] BASE = 24'h010000;

  localparam int PH_IDLE = 0, PH_CMD = 1, PH_LOAD = 2, PH_DONE = 3, PH_ERR = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        boot_start;
  logic        cpu_rst_hold, boot_busy, boot_done, boot_err;
  logic [15:0] boot_csum;

  flash_boot_ctrl_if #(.IMEM_WIDTH(IW), .FLASH_WIDTH(FW)) bus ();

  flash_boot_ctrl #(
    .IMEM_WIDTH  (IW),
    .FLASH_WIDTH (FW),
    .BOOT_BASE   (BASE),
    .BOOT_BYTES  (NB),
    .TIMEOUT     (TMO),
    .AUTO_BOOT   (1'b1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .boot_start   (boot_start),
    .bus          (bus),
    .cpu_rst_hold (cpu_rst_hold),
    .boot_busy    (boot_busy),
    .boot_done    (boot_done),
    .boot_err     (boot_err),
    .boot_csum    (boot_csum)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  // Reference model: tracks what the loader should be doing in terms of
  // phase, bytes taken, idle cycles since the last progress, and the last
  // RAM write it should have issued.
  int          m_ph, m_cnt, m_idle;
  logic [15:0] m_csum;
  logic        m_hold, m_auto;
  logic [3:0]  m_wen;
  logic [16:0] m_addr;
  logic [7:0]  m_din;

  function automatic logic [93:0] obs_vec();
    return {bus.flash_cmd_valid, bus.flash_cmd_addr, bus.flash_cmd_len,
            bus.ram_addr, bus.ram_wen, bus.ram_din,
            cpu_rst_hold, boot_busy, boot_done, boot_err, boot_csum};
  endfunction

  function automatic logic [93:0] exp_vec();
    return {(m_ph == PH_CMD), BASE, 20'(NB),
            m_addr, m_wen, m_din,
            m_hold, (m_ph == PH_CMD || m_ph == PH_LOAD),
            (m_ph == PH_DONE), (m_ph == PH_ERR), m_csum};
  endfunction

  task automatic model_reset();
    m_ph = PH_IDLE; m_cnt = 0; m_idle = 0; m_csum = '0;
    m_hold = 1'b1; m_auto = 1'b1; m_wen = '0; m_addr = '0; m_din = '0;
  endtask

  task automatic model_step(input bit st, input bit rdy, input bit rv, input logic [7:0] d);
    int  pre;
    bit  restart;
    pre     = m_ph;
    restart = 1'b0;
    m_wen   = '0;
    case (m_ph)
      PH_IDLE: restart = st || m_auto;
      PH_CMD: begin
        if (rdy) begin
          m_ph = PH_LOAD; m_idle = 0;
        end else begin
          m_idle++;
          if (m_idle == TMO) m_ph = PH_ERR;
        end
      end
      PH_LOAD: begin
        if (rv) begin
          m_wen  = 4'(1 << (m_cnt % 4));
          m_addr = 17'(m_cnt / 4);
          m_din  = d;
          m_csum = m_csum + 16'(d);
          m_cnt++;
          m_idle = 0;
          if (m_cnt == NB) m_ph = PH_DONE;
        end else begin
          m_idle++;
          if (m_idle == TMO) m_ph = PH_ERR;
        end
      end
      default: restart = st;
    endcase
    if (restart) begin
      m_ph = PH_CMD; m_cnt = 0; m_idle = 0; m_csum = '0; m_hold = 1'b1;
    end else if (pre == PH_DONE) begin
      m_hold = 1'b0;
    end
    m_auto = 1'b0;
  endtask

  // Called just after a falling edge: applies one cycle of inputs, advances
  // the model across the next rising edge and returns at the following
  // falling edge, where outputs are sampled.
  task automatic drive(input bit st, input bit rdy, input bit rv, input logic [7:0] d);
    boot_start            = st;
    bus.flash_cmd_ready   = rdy;
    bus.flash_rdata_valid = rv;
    bus.flash_rdata       = d;
    model_step(st, rdy, rv, d);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; boot_start = 1'b0;
    bus.flash_cmd_ready = 1'b0; bus.flash_rdata_valid = 1'b0; bus.flash_rdata = '0;
    #1;
    model_reset();
    repeat (2) @(negedge clk);
    n_vec++;
    if (obs_vec() !== exp_vec()) begin
      n_miss++;
      $display("FAIL reset: got %h want %h", obs_vec(), exp_vec());
    end
    rst = 1'b0;
  endtask

  task automatic test_basic_load();
    int wq[$]; int aq[$]; int cq[$];
    int done_c, hold_c;
    done_c = -1; hold_c = -1;
    for (int c = 0; c < 14; c++) begin
      drive(1'b0, (c == 2), (c >= 3 && c <= 10), 8'(17 * (c - 2)));
      n_vec++;
      if (obs_vec() !== exp_vec()) begin
        n_miss++;
        $display("FAIL basic c%0d: got %h want %h", c, obs_vec(), exp_vec());
      end
      if (bus.ram_wen != 4'd0) begin wq.push_back(int'(bus.ram_wen)); aq.push_back(int'(bus.ram_addr)); cq.push_back(c); end
      if (boot_done === 1'b1 && done_c < 0) done_c = c;
      if (cpu_rst_hold === 1'b0 && hold_c < 0) hold_c = c;
    end
    n_vec++;
    if (wq.size() != 8) begin
      n_miss++;
      $display("FAIL basic_nwrites: got %0d want 8", wq.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        n_vec++;
        if (wq[i] != (1 << (i % 4)) || aq[i] != i / 4 || cq[i] != 3 + i) begin
          n_miss++;
          $display("FAIL basic_write%0d: got wen %0d addr %0d cyc %0d want wen %0d addr %0d cyc %0d",
                   i, wq[i], aq[i], cq[i], 1 << (i % 4), i / 4, 3 + i);
        end
      end
    end
    n_vec++;
    if (boot_csum !== 16'h0264 || done_c != 10 || hold_c != 11) begin
      n_miss++;
      $display("FAIL basic_status: got csum %h done@%0d hold_low@%0d want 0264 10 11",
               boot_csum, done_c, hold_c);
    end
  endtask

  task automatic test_gapped_restart();
    int wq[$]; int aq[$]; int cq[$];
    int k, err_seen;
    k = 0; err_seen = 0;
    for (int c = 0; c < 26; c++) begin
      bit rv;
      logic [7:0] d;
      rv = (c >= 2 && (c - 2) % 3 == 0 && k < 8);
      d  = rv ? 8'(17 * (k + 1)) : 8'hA5;
      if (rv) k++;
      drive((c == 0 || c == 6), (c == 1), rv, d);
      n_vec++;
      if (obs_vec() !== exp_vec()) begin
        n_miss++;
        $display("FAIL gapped c%0d: got %h want %h", c, obs_vec(), exp_vec());
      end
      if (c == 0) begin
        n_vec++;
        if (cpu_rst_hold !== 1'b1 || boot_done !== 1'b0 || boot_busy !== 1'b1) begin
          n_miss++;
          $display("FAIL restart_edge: got hold %b done %b busy %b want 1 0 1",
                   cpu_rst_hold, boot_done, boot_busy);
        end
      end
      if (boot_err === 1'b1) err_seen = 1;
      if (bus.ram_wen != 4'd0) begin wq.push_back(int'(bus.ram_wen)); aq.push_back(int'(bus.ram_addr)); cq.push_back(c); end
    end
    n_vec++;
    if (wq.size() != 8) begin
      n_miss++;
      $display("FAIL gapped_nwrites: got %0d want 8", wq.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        n_vec++;
        if (wq[i] != (1 << (i % 4)) || aq[i] != i / 4 || cq[i] != 2 + 3 * i) begin
          n_miss++;
          $display("FAIL gapped_write%0d: got wen %0d addr %0d cyc %0d want wen %0d addr %0d cyc %0d",
                   i, wq[i], aq[i], cq[i], 1 << (i % 4), i / 4, 2 + 3 * i);
        end
      end
    end
    n_vec++;
    if (boot_csum !== 16'h0264 || boot_done !== 1'b1 || err_seen != 0) begin
      n_miss++;
      $display("FAIL gapped_status: got csum %h done %b err_seen %0d want 0264 1 0",
               boot_csum, boot_done, err_seen);
    end
  endtask

  task automatic test_timeout();
    int err_c, late_wen, hold_low;
    err_c = -1; late_wen = 0; hold_low = 0;
    for (int c = 0; c < 30; c++) begin
      drive((c == 0), (c == 1), ((c >= 2 && c <= 6) || c == 25), 8'($urandom));
      n_vec++;
      if (obs_vec() !== exp_vec()) begin
        n_miss++;
        $display("FAIL timeout c%0d: got %h want %h", c, obs_vec(), exp_vec());
      end
      if (boot_err === 1'b1 && err_c < 0) err_c = c;
      if (c > 6 && bus.ram_wen != 4'd0) late_wen++;
      if (cpu_rst_hold !== 1'b1) hold_low++;
    end
    // 5th strobe is taken at c=6; 16 idle edges later the error is raised.
    n_vec++;
    if (err_c != 22 || late_wen != 0 || hold_low != 0) begin
      n_miss++;
      $display("FAIL timeout_status: got err@%0d late_wen %0d hold_low %0d want 22 0 0",
               err_c, late_wen, hold_low);
    end
  endtask

  task automatic test_cmd_timeout();
    int err_c;
    err_c = -1;
    for (int c = 0; c < 20; c++) begin
      drive((c == 0), 1'b0, 1'b0, 8'h00);
      n_vec++;
      if (obs_vec() !== exp_vec()) begin
        n_miss++;
        $display("FAIL cmd_timeout c%0d: got %h want %h", c, obs_vec(), exp_vec());
      end
      if (c == 0) begin
        n_vec++;
        if (boot_err !== 1'b0 || bus.flash_cmd_valid !== 1'b1) begin
          n_miss++;
          $display("FAIL cmd_restart: got err %b valid %b want 0 1", boot_err, bus.flash_cmd_valid);
        end
      end
      if (boot_err === 1'b1 && err_c < 0) err_c = c;
    end
    n_vec++;
    if (err_c != 16) begin
      n_miss++;
      $display("FAIL cmd_timeout_cycle: got %0d want 16", err_c);
    end
  endtask

  task automatic test_stray_strobes();
    logic [7:0] dat [16];
    logic [15:0] sum;
    int nw, first_ok;
    nw = 0; first_ok = 0; sum = '0;
    for (int c = 0; c < 16; c++) dat[c] = 8'($urandom);
    for (int c = 4; c <= 11; c++) sum = sum + 16'(dat[c]);
    for (int c = 0; c < 16; c++) begin
      drive((c == 0), (c == 3), 1'b1, dat[c]);
      n_vec++;
      if (obs_vec() !== exp_vec()) begin
        n_miss++;
        $display("FAIL stray c%0d: got %h want %h", c, obs_vec(), exp_vec());
      end
      if (bus.ram_wen != 4'd0) begin
        if (nw == 0 && c == 4 && bus.ram_wen == 4'd1 && bus.ram_addr == 17'd0 && bus.ram_din == dat[4])
          first_ok = 1;
        nw++;
      end
    end
    n_vec++;
    if (nw != 8 || first_ok != 1 || boot_csum !== sum) begin
      n_miss++;
      $display("FAIL stray_status: got writes %0d first_ok %0d csum %h want 8 1 %h",
               nw, first_ok, boot_csum, sum);
    end
  endtask

  task automatic test_mid_reset();
    for (int c = 0; c < 5; c++) begin
      drive((c == 0), (c == 1), (c >= 2), 8'($urandom));
      n_vec++;
      if (obs_vec() !== exp_vec()) begin
        n_miss++;
        $display("FAIL midrst_pre c%0d: got %h want %h", c, obs_vec(), exp_vec());
      end
    end
    boot_start = 1'b0; bus.flash_cmd_ready = 1'b0; bus.flash_rdata_valid = 1'b0;
    rst = 1'b1;
    #1;
    model_reset();
    n_vec++;
    if (obs_vec() !== exp_vec()) begin
      n_miss++;
      $display("FAIL midrst_async: got %h want %h", obs_vec(), exp_vec());
    end
    @(negedge clk);
    n_vec++;
    if (obs_vec() !== exp_vec()) begin
      n_miss++;
      $display("FAIL midrst_held: got %h want %h", obs_vec(), exp_vec());
    end
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    n_vec++;
    if (obs_vec() !== exp_vec() || bus.flash_cmd_valid !== 1'b1) begin
      n_miss++;
      $display("FAIL midrst_autoboot: got %h want %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_random();
    int quiet;
    quiet = 0;
    for (int c = 0; c < 600; c++) begin
      bit st, rdy, rv;
      if (quiet == 0 && $urandom_range(0, 99) == 0) quiet = $urandom_range(10, 20);
      if (m_ph == PH_DONE || m_ph == PH_ERR) st = ($urandom_range(0, 5) == 0);
      else st = ($urandom_range(0, 63) == 0);
      rdy = ($urandom_range(0, 2) == 0);
      rv  = (quiet == 0) && ($urandom_range(0, 2) != 0);
      if (quiet > 0) quiet--;
      drive(st, rdy, rv, 8'($urandom));
      n_vec++;
      if (obs_vec() !== exp_vec()) begin
        n_miss++;
        $display("FAIL random c%0d: got %h want %h", c, obs_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_gapped_restart();
    test_timeout();
    test_cmd_timeout();
    test_stray_strobes();
    test_mid_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion want completion");
    $fatal(1);
  end

endmodule
